// File: rtl/color_shape_pkg.sv
// Shared types, output codes, pixel constants and parameter defaults for the
// colour/shape detector.
package color_shape_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_COLOR = 2'd2,
        ST_SHAPE = 2'd3
    } state_t;

    localparam logic [1:0] COLOR_NONE = 2'b00;
    localparam logic [1:0] COLOR_RED  = 2'b01;
    localparam logic [1:0] COLOR_BLUE = 2'b10;

    localparam logic [1:0] SHAPE_UNKNOWN  = 2'b00;
    localparam logic [1:0] SHAPE_TRIANGLE = 2'b01;
    localparam logic [1:0] SHAPE_SQUARE   = 2'b10;
    localparam logic [1:0] SHAPE_DIAMOND  = 2'b11;

    // RGB332, exact match only
    localparam logic [7:0] PIX_RED  = 8'b111_000_00;
    localparam logic [7:0] PIX_BLUE = 8'b000_000_11;

    localparam int unsigned DEF_WIN_X0        = 58;
    localparam int unsigned DEF_WIN_W         = 60;
    localparam int unsigned DEF_WIN_Y0        = 37;
    localparam int unsigned DEF_WIN_H         = 69;
    localparam int unsigned DEF_CNT_W         = 12;
    localparam int unsigned DEF_R_THRESH      = 300;
    localparam int unsigned DEF_B_THRESH      = 300;
    localparam int unsigned DEF_SHAPE_TOL     = 40;
    localparam int unsigned DEF_STABLE_FRAMES = 2;

endpackage

// File: rtl/band_counter.sv
// Three saturating per-band pixel counters for one colour; sel picks the band
// that an inc pulse advances.
module band_counter
    import color_shape_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [1:0]       sel,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [3];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (inc && sel == 2'(i) && cnt_q[i] != CNT_MAX)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];

endmodule

// File: rtl/color_shape_detector.sv
// Counts red/blue pixels in three horizontal bands of a fixed window per frame,
// classifies colour and shape, and publishes results once they are stable.
//
// state | meaning
// IDLE  | waiting for a vsync fall (start of active frame)
// ACCUM | counting window pixels until the vsync rise
// COLOR | pick winning colour, latch its three band counts
// SHAPE | classify the band profile, queue the stability update
module color_shape_detector
    import color_shape_pkg::*;
#(
    parameter int unsigned WIN_X0        = DEF_WIN_X0,
    parameter int unsigned WIN_W         = DEF_WIN_W,
    parameter int unsigned WIN_Y0        = DEF_WIN_Y0,
    parameter int unsigned WIN_H         = DEF_WIN_H,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned R_THRESH      = DEF_R_THRESH,
    parameter int unsigned B_THRESH      = DEF_B_THRESH,
    parameter int unsigned SHAPE_TOL     = DEF_SHAPE_TOL,
    parameter int unsigned STABLE_FRAMES = DEF_STABLE_FRAMES
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PIXEL_IN,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    output logic [1:0] COLOR,
    output logic [1:0] SHAPE,
    output logic       STABLE,
    output logic       FRAME_DONE
);

    localparam int unsigned BAND_H = WIN_H / 3;
    localparam int unsigned SUM_W  = CNT_W + 2;

    state_t state_q, state_d;
    logic   vsync_q, armed_q, rise, fall;
    logic   clr_cnt, count_en;

    logic [31:0] x_ext, y_ext, y_off;
    logic        in_win;
    logic [1:0]  band_sel;
    logic        inc_red, inc_blue;

    logic [CNT_W-1:0] r0, r1, r2, bl0, bl1, bl2;
    logic [SUM_W-1:0] rt, bt;
    logic [1:0]       color_sel;
    logic [CNT_W-1:0] sel0, sel1, sel2;

    logic [1:0]       color_q, shape_q;
    logic [CNT_W-1:0] b0_q, b1_q, b2_q;
    logic             upd_q;

    logic [31:0] e0, e1, e2, d01, d21;
    logic [1:0]  shape_sel;

    logic [3:0] prev_q, run_q, run_next, cand;
    logic       load;

    // A fall only counts once blanking has been seen since reset, so releasing
    // reset in the middle of an active frame cannot start a partial frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vsync_q <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            vsync_q <= VGA_VSYNC_NEG;
            armed_q <= armed_q | VGA_VSYNC_NEG;
        end
    end

    assign rise = VGA_VSYNC_NEG & ~vsync_q;
    assign fall = ~VGA_VSYNC_NEG & vsync_q & armed_q;

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        clr_cnt  = 1'b0;
        count_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_ACCUM;
                    clr_cnt = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (rise) state_d  = ST_COLOR;
                else      count_en = 1'b1;
            end
            ST_COLOR: state_d = ST_SHAPE;
            ST_SHAPE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_ext  = {22'd0, VGA_PIXEL_X};
        y_ext  = {22'd0, VGA_PIXEL_Y};
        y_off  = y_ext - WIN_Y0;
        in_win = (x_ext >= WIN_X0) && (x_ext <= WIN_X0 + WIN_W - 1) &&
                 (y_ext >= WIN_Y0) && (y_ext <= WIN_Y0 + WIN_H - 1);
        if (y_off < BAND_H)          band_sel = 2'd0;
        else if (y_off < 2 * BAND_H) band_sel = 2'd1;
        else                         band_sel = 2'd2;
    end

    assign inc_red  = count_en & in_win & (PIXEL_IN == PIX_RED);
    assign inc_blue = count_en & in_win & (PIXEL_IN == PIX_BLUE);

    band_counter #(.CNT_W(CNT_W)) u_red (
        .clk   (CLK),
        .reset (RESET),
        .clr   (clr_cnt),
        .inc   (inc_red),
        .sel   (band_sel),
        .cnt0  (r0),
        .cnt1  (r1),
        .cnt2  (r2)
    );

    band_counter #(.CNT_W(CNT_W)) u_blue (
        .clk   (CLK),
        .reset (RESET),
        .clr   (clr_cnt),
        .inc   (inc_blue),
        .sel   (band_sel),
        .cnt0  (bl0),
        .cnt1  (bl1),
        .cnt2  (bl2)
    );

    always_comb begin
        rt = SUM_W'(r0) + SUM_W'(r1) + SUM_W'(r2);
        bt = SUM_W'(bl0) + SUM_W'(bl1) + SUM_W'(bl2);
        if (32'(rt) >= R_THRESH && rt >= bt) color_sel = COLOR_RED;
        else if (32'(bt) >= B_THRESH)        color_sel = COLOR_BLUE;
        else                                 color_sel = COLOR_NONE;
        if (color_sel == COLOR_BLUE) begin
            sel0 = bl0;
            sel1 = bl1;
            sel2 = bl2;
        end else begin
            sel0 = r0;
            sel1 = r1;
            sel2 = r2;
        end
    end

    // Band counts widened so tolerance sums and differences cannot wrap.
    always_comb begin
        e0  = 32'(b0_q);
        e1  = 32'(b1_q);
        e2  = 32'(b2_q);
        d01 = (e0 > e1) ? e0 - e1 : e1 - e0;
        d21 = (e2 > e1) ? e2 - e1 : e1 - e2;
        if (color_q == COLOR_NONE)                            shape_sel = SHAPE_UNKNOWN;
        else if (e0 < e1 && e1 < e2 && (e2 - e0) > SHAPE_TOL) shape_sel = SHAPE_TRIANGLE;
        else if (e1 > e0 + SHAPE_TOL && e1 > e2 + SHAPE_TOL)  shape_sel = SHAPE_DIAMOND;
        else if (d01 <= SHAPE_TOL && d21 <= SHAPE_TOL)        shape_sel = SHAPE_SQUARE;
        else                                                  shape_sel = SHAPE_UNKNOWN;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            color_q <= COLOR_NONE;
            shape_q <= SHAPE_UNKNOWN;
            b0_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= (state_q == ST_SHAPE);
            if (state_q == ST_COLOR) begin
                color_q <= color_sel;
                b0_q    <= sel0;
                b1_q    <= sel1;
                b2_q    <= sel2;
            end
            if (state_q == ST_SHAPE) shape_q <= shape_sel;
        end
    end

    always_comb begin
        cand = {color_q, shape_q};
        if (cand != prev_q)    run_next = 4'd1;
        else if (run_q == 4'hF) run_next = 4'hF;
        else                   run_next = run_q + 4'd1;
        load = ({28'd0, run_next} >= STABLE_FRAMES);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_q     <= {COLOR_NONE, SHAPE_UNKNOWN};
            run_q      <= 4'd0;
            COLOR      <= COLOR_NONE;
            SHAPE      <= SHAPE_UNKNOWN;
            STABLE     <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= upd_q;
            if (upd_q) begin
                prev_q <= cand;
                run_q  <= run_next;
                STABLE <= load;
                if (load) begin
                    COLOR <= color_q;
                    SHAPE <= shape_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_shape_detector.sv
// Frame-level scoreboard bench: each frame's expected outputs are queued at the
// vsync rise and compared when FRAME_DONE pulses.
module tb_color_shape_detector;
    import color_shape_pkg::*;

    localparam int WX0 = 58, WW = 60, WY0 = 37, WH = 69, BH = 23;
    localparam int SF  = 2;
    localparam int TOL = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix;
    logic [9:0] px, py;
    logic       vs;
    logic [1:0] color, shape, color8, shape8;
    logic       stable, frame_done, stable8, frame_done8;

    always #5 clk = ~clk;

    color_shape_detector dut (
        .CLK(clk), .RESET(rst), .PIXEL_IN(pix), .VGA_PIXEL_X(px), .VGA_PIXEL_Y(py),
        .VGA_VSYNC_NEG(vs), .COLOR(color), .SHAPE(shape), .STABLE(stable),
        .FRAME_DONE(frame_done)
    );

    color_shape_detector #(.CNT_W(8), .R_THRESH(250), .STABLE_FRAMES(1)) dut8 (
        .CLK(clk), .RESET(rst), .PIXEL_IN(pix), .VGA_PIXEL_X(px), .VGA_PIXEL_Y(py),
        .VGA_VSYNC_NEG(vs), .COLOR(color8), .SHAPE(shape8), .STABLE(stable8),
        .FRAME_DONE(frame_done8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    typedef struct {
        logic [1:0] c;
        logic [1:0] s;
        logic       st;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always @(negedge clk) begin
        if (!rst && frame_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_frame_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_color"},  color,  e.c);
                chk({e.tag, "_shape"},  shape,  e.s);
                chk({e.tag, "_stable"}, stable, e.st);
            end
        end
    end

    // Reference model of classification and stability filtering
    logic [3:0] m_prev;
    logic [1:0] m_c, m_s;
    logic       m_st;
    int         m_run;

    task automatic model_reset();
        m_prev = 4'b0000;
        m_c    = 2'b00;
        m_s    = 2'b00;
        m_st   = 1'b0;
        m_run  = 0;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [3:0] classify(input int r0, r1, r2, b0, b1, b2);
        int rt, bt, x0, x1, x2;
        logic [1:0] c, s;
        rt = r0 + r1 + r2;
        bt = b0 + b1 + b2;
        if (rt >= 300 && rt >= bt) begin c = 2'b01; x0 = r0; x1 = r1; x2 = r2; end
        else if (bt >= 300)        begin c = 2'b10; x0 = b0; x1 = b1; x2 = b2; end
        else                       begin c = 2'b00; x0 = 0;  x1 = 0;  x2 = 0;  end
        if (c == 2'b00)                                   s = 2'b00;
        else if (x0 < x1 && x1 < x2 && x2 - x0 > TOL)     s = 2'b01;
        else if (x1 > x0 + TOL && x1 > x2 + TOL)          s = 2'b11;
        else if (iabs(x0 - x1) <= TOL && iabs(x2 - x1) <= TOL) s = 2'b10;
        else                                              s = 2'b00;
        return {c, s};
    endfunction

    task automatic drive(input logic [7:0] p, input int x, input int y);
        @(negedge clk);
        pix = p;
        px  = 10'(x);
        py  = 10'(y);
    endtask

    task automatic emit_band(input logic [7:0] p, input int band, input int n);
        for (int k = 0; k < n; k++)
            drive(p, WX0 + k % WW, WY0 + band * BH + (k / WW) % BH);
    endtask

    task automatic frame_start();
        @(negedge clk);
        vs = 1'b1;
        pix = 8'h00;
        repeat (3) @(negedge clk);
        vs = 1'b0;
        // pixels that must never be counted: outside window or wrong code
        drive(PIX_RED, WX0 - 1, WY0);
        drive(PIX_RED, WX0 + WW, WY0);
        drive(PIX_RED, WX0, WY0 - 1);
        drive(PIX_RED, WX0, WY0 + WH);
        drive(8'hE1, WX0, WY0);
        drive(8'h07, WX0, WY0);
    endtask

    // Drives the rise with a red window pixel in the same cycle; returns the
    // number of edges after the rise edge at which FRAME_DONE was seen.
    task automatic frame_end(output int lat, output int pulses);
        @(negedge clk);
        vs  = 1'b1;
        pix = PIX_RED;
        px  = 10'(WX0 + 1);
        py  = 10'(WY0 + 1);
        @(posedge clk);
        #1 pix = 8'h00;
        lat = 0;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
    endtask

    task automatic run_frame(input string tag, input int r0, r1, r2, b0, b1, b2);
        logic [3:0] cl;
        int lat, pulses;
        frame_start();
        emit_band(PIX_RED, 0, r0);
        emit_band(PIX_RED, 1, r1);
        emit_band(PIX_RED, 2, r2);
        emit_band(PIX_BLUE, 0, b0);
        emit_band(PIX_BLUE, 1, b1);
        emit_band(PIX_BLUE, 2, b2);
        cl = classify(r0, r1, r2, b0, b1, b2);
        if (cl == m_prev) m_run = (m_run < 15) ? m_run + 1 : 15;
        else              m_run = 1;
        m_prev = cl;
        if (m_run >= SF) begin
            m_c  = cl[3:2];
            m_s  = cl[1:0];
            m_st = 1'b1;
        end else begin
            m_st = 1'b0;
        end
        sb.push_back('{c: m_c, s: m_s, st: m_st, tag: tag});
        frame_end(lat, pulses);
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    task automatic reset_mid_frame();
        int lat, pulses;
        frame_start();
        emit_band(PIX_RED, 0, 200);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst_color",  color,  0);
        chk("midrst_shape",  shape,  0);
        chk("midrst_stable", stable, 0);
        emit_band(PIX_RED, 1, 500);
        frame_end(lat, pulses);
        chk("midrst_no_done", pulses, 0);
    endtask

    initial begin
        rst = 1'b1;
        vs  = 1'b1;
        pix = 8'h00;
        px  = '0;
        py  = '0;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_color",      color,      0);
        chk("reset_shape",      shape,      0);
        chk("reset_stable",     stable,     0);
        chk("reset_frame_done", frame_done, 0);

        run_frame("red_solid1", 1380, 1380, 1380, 0, 0, 0);
        run_frame("red_solid2", 1380, 1380, 1380, 0, 0, 0);
        run_frame("blue_tri1",  0, 0, 0, 100, 500, 900);
        run_frame("blue_tri2",  0, 0, 0, 100, 500, 900);
        run_frame("red299_a",   100, 100, 99, 0, 0, 0);
        run_frame("red299_b",   100, 100, 99, 0, 0, 0);
        run_frame("red300_a",   100, 100, 100, 0, 0, 0);
        run_frame("red300_b",   100, 100, 100, 0, 0, 0);
        run_frame("tie400",     133, 134, 133, 100, 200, 100);
        run_frame("alt_blue1",  0, 0, 0, 0, 400, 0);
        run_frame("alt_red",    0, 400, 0, 0, 0, 0);
        run_frame("alt_blue2",  0, 0, 0, 0, 400, 0);
        run_frame("sat1000",    1000, 0, 0, 0, 0, 0);
        chk("cnt8_color",  color8,  1);
        chk("cnt8_shape",  shape8,  0);
        chk("cnt8_stable", stable8, 1);

        reset_mid_frame();
        run_frame("post_rst1", 1380, 1380, 1380, 0, 0, 0);
        run_frame("post_rst2", 1380, 1380, 1380, 0, 0, 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
